pst_phase_scheduler: RTL
========================

# pst_phase_scheduler

Timebase and training-sequence controller for the two-layer theta predictive stack (phase neuron L1, predictive phase L2, theta sequence predictor L3). It generates `global_phase` and `cycle_start`, gates the stimulus into L1, and drives `l3_freeze` through a warm-up / train / locked schedule. The schedule is driven by per-cycle samples of the L2/L3 error outputs and the L1 fire flag. It sits directly above the stack and is the only source of its timing.

## Interface
- PHASE_DIV, 8'd1: clocks per phase step (must be ≥1).
- WARMUP_CYCLES, 8'd16: completed theta cycles with L3 frozen before training.
- ERR_LOCK, 8'd8: `error_L3` at or below this value counts as a good cycle.
- LOCK_CYCLES, 8'd4: consecutive good cycles required to lock.
- ERR_UNLOCK, 8'd32: `error_L3` above this value while locked forces relearn.
- MISS_LIMIT, 8'd3: consecutive non-firing cycles that trigger a fault.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; asynchronous and active-high.
- start  in  1  pulse; leaves IDLE.
- stop  in  1  level or pulse; returns to IDLE from any state.
- stim_in  in  8  raw stimulus current.
- fired_L1_in  in  1  L1 fired in the current theta cycle.
- error_L2_in  in  8  L2 error magnitude.
- error_L3_in  in  8  L3 error magnitude.
- global_phase  out  8  phase counter.
- cycle_start  out  1  one-clock pulse at the phase-0 entry.
- input_current  out  8  gated stimulus.
- l3_freeze  out  1  freezes L3 feedback into L2.
- state  out  3  IDLE=0, WARMUP=1, TRAIN=2, LOCKED=3, FAULT=4.
- cycle_count  out  16  completed theta cycles since start; saturates at 16'hFFFF.
- relearn_count  out  8  LOCKED→TRAIN transitions; saturates at 255.
- err_l2_sample  out  8  `error_L2_in` latched at the last cycle boundary.

## Operation
- **Reset values.**
  - All outputs 0, except `l3_freeze`=1.
  - `state` is IDLE; prescaler and all internal counters are 0.
- **IDLE.**
  - Phase and prescaler are held at 0; `cycle_start`=0; `input_current`=0; `l3_freeze`=1.
  - On `start`: go to WARMUP. `cycle_count`, `relearn_count`, good counter and miss counter clear.
- **Timebase** (all states except IDLE and FAULT).
  - The prescaler counts 0..PHASE_DIV-1.
  - At the terminal prescaler count, `global_phase` increments. It wraps 255→0 with no skip.
  - `cycle_start`=1 for exactly one clock: the first clock `global_phase`==0 of each cycle, including the first cycle after `start`.
- **Boundary sample.** This happens at every `cycle_start` except the first after `start`.
  - Latch `fired_L1_in`, `error_L2_in` and `error_L3_in`; these describe the completed cycle.
  - `cycle_count`++.
  - Miss counter: increments if the latched fire flag is 0, otherwise clears.
- **WARMUP.**
  - `l3_freeze`=1; `input_current`=`stim_in` (combinational pass-through).
  - Move to TRAIN at the boundary where `cycle_count` reaches WARMUP_CYCLES.
- **TRAIN.**
  - `l3_freeze`=0.
  - Good counter: increments when `error_L3` ≤ ERR_LOCK, otherwise clears.
  - Move to LOCKED when the good counter reaches LOCK_CYCLES.
- **LOCKED.**
  - `l3_freeze`=0.
  - If the sampled `error_L3` > ERR_UNLOCK: go to TRAIN, clear the good counter, `relearn_count`++.
- **FAULT.**
  - Entered from WARMUP, TRAIN or LOCKED when the miss counter reaches MISS_LIMIT.
  - Phase is frozen at its current value; `cycle_start`=0; `input_current`=0; `l3_freeze`=1.
  - Left only via `stop` or `rst`.
- **Priority.** `rst` > `stop` > fault > unlock/lock/warm-up transition.
  - `start` is ignored outside IDLE.
  - `start` and `stop` asserted in the same clock: stop wins, stay in IDLE.
- **Error comparisons** are unsigned 8-bit.

## Timing
- `start` sampled at edge N: `state`=WARMUP, `global_phase`=0 and `cycle_start`=1 after edge N+1.
- With PHASE_DIV=1, a theta cycle is 256 clocks, and `cycle_start` recurs every 256 clocks.
- The cycle that ends with the LOCK_CYCLES-th good sample sees `state` change in the clock after that `cycle_start`. The same registered timing applies to the WARMUP→TRAIN and LOCKED→TRAIN transitions.
- **Outputs:**
  - `l3_freeze` is a registered decode of `state`.
  - `input_current` is combinational from `state` and `stim_in`.
  - All other outputs are registered.
- `rst` asserted mid-cycle: all outputs take their reset values immediately (asynchronously).

## Structure
- Shared package `pst_pkg`: state encoding localparams, PHASE_W=8, CNT_W=16.
- One sub-module, `pst_phase_timebase`: prescaler, phase counter and `cycle_start` generation, with a run/hold input. The FSM, sample registers and counters stay in the top level.

## Test plan
- **Bring-up.** PHASE_DIV=1; reset, then `start`.
  - `cycle_start` is seen at clocks 1, 257, 513.
  - `global_phase` is 255 at clock 256.
- **Warm-up.** Stimulus 8'd60 with `fired_L1_in`=1 constantly.
  - `l3_freeze`=1 through 16 boundaries, then TRAIN with `l3_freeze`=0.
- **Lock.** In TRAIN, `error_L3` sequence 20,5,5,5,5.
  - LOCKED after the fifth sample, `relearn_count`=0.
- **Relearn.** In LOCKED, `error_L3`=40 at one boundary.
  - TRAIN, `relearn_count`=1.
  - A sample of 32 instead keeps the block in LOCKED.
- **Fault.** `fired_L1_in`=0 for 3 consecutive cycles while in TRAIN.
  - FAULT, phase frozen, `input_current`=0.
  - `stop` returns to IDLE.
- **Edges.**
  - `start` and `stop` together: stays IDLE.
  - `rst` at phase 100: every output returns to its reset value immediately.
  - PHASE_DIV=3: `cycle_start` period is 768 clocks.

Source files
------------

// File: rtl/pst_pkg.sv
// Shared definitions for the theta-stack phase scheduler: state encoding and widths.
package pst_pkg;
  localparam int PHASE_W = 8;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_TRAIN  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAULT  = 3'd4
  } pst_state_e;

  // States in which the timebase advances and stimulus reaches L1.
  function automatic logic is_run(input pst_state_e st);
    return (st == ST_WARMUP) || (st == ST_TRAIN) || (st == ST_LOCKED);
  endfunction
endpackage

// File: rtl/pst_phase_timebase.sv
// Prescaler + 8-bit phase counter; cycle_start marks the first clock of phase 0.
module pst_phase_timebase
  import pst_pkg::*;
#(
  parameter logic [7:0] PHASE_DIV = 8'd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               clear,
  output logic [PHASE_W-1:0] phase,
  output logic               cycle_start,
  output logic               wrap
);
  logic [7:0]         pre_q, pre_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               cs_q, cs_d;
  logic               started_q, started_d;
  logic               term;

  assign term = (pre_q == PHASE_DIV - 8'd1);
  // Wrap into phase 0 of a later cycle: the boundary-sample strobe.
  assign wrap = run && started_q && term && (phase_q == '1);

  always_comb begin
    pre_d     = pre_q;
    phase_d   = phase_q;
    started_d = started_q;
    cs_d      = 1'b0;
    if (clear) begin
      pre_d     = '0;
      phase_d   = '0;
      started_d = 1'b0;
    end else if (run) begin
      if (!started_q) begin
        // First clock after start: phase 0 is entered without advancing.
        started_d = 1'b1;
        cs_d      = 1'b1;
      end else if (term) begin
        pre_d   = '0;
        phase_d = phase_q + 1'b1;
        cs_d    = (phase_q == '1);
      end else begin
        pre_d = pre_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      phase_q   <= '0;
      cs_q      <= 1'b0;
      started_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      phase_q   <= phase_d;
      cs_q      <= cs_d;
      started_q <= started_d;
    end
  end

  assign phase       = phase_q;
  assign cycle_start = cs_q;
endmodule

// File: rtl/pst_phase_scheduler.sv
// Timebase and warm-up/train/locked schedule controller for the theta predictive stack.
module pst_phase_scheduler
  import pst_pkg::*;
#(
  parameter logic [7:0] PHASE_DIV     = 8'd1,
  parameter logic [7:0] WARMUP_CYCLES = 8'd16,
  parameter logic [7:0] ERR_LOCK      = 8'd8,
  parameter logic [7:0] LOCK_CYCLES   = 8'd4,
  parameter logic [7:0] ERR_UNLOCK    = 8'd32,
  parameter logic [7:0] MISS_LIMIT    = 8'd3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         stim_in,
  input  logic               fired_L1_in,
  input  logic [7:0]         error_L2_in,
  input  logic [7:0]         error_L3_in,
  output logic [PHASE_W-1:0] global_phase,
  output logic               cycle_start,
  output logic [7:0]         input_current,
  output logic               l3_freeze,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [7:0]         relearn_count,
  output logic [7:0]         err_l2_sample
);
  pst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rel_q, rel_d;
  logic [7:0]       good_q, good_d;
  logic [7:0]       miss_q, miss_d;
  logic             fired_s_q, fired_s_d;
  logic [7:0]       e2_q, e2_d, e3_q, e3_d;
  logic             smp_vld_q, smp_vld_d;
  logic             freeze_q, freeze_d;
  logic             tb_run, tb_clear, wrap;

  assign tb_run   = is_run(state_q) && is_run(state_d);
  assign tb_clear = (state_d == ST_IDLE);

  pst_phase_timebase #(.PHASE_DIV(PHASE_DIV)) u_tb (
    .clk         (clk),
    .rst         (rst),
    .run         (tb_run),
    .clear       (tb_clear),
    .phase       (global_phase),
    .cycle_start (cycle_start),
    .wrap        (wrap)
  );

  // Samples are latched on the wrap edge and acted upon one clock later.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    good_d    = good_q;
    miss_d    = miss_q;
    fired_s_d = fired_s_q;
    e2_d      = e2_q;
    e3_d      = e3_q;
    smp_vld_d = wrap;
    if (wrap) begin
      fired_s_d = fired_L1_in;
      e2_d      = error_L2_in;
      e3_d      = error_L3_in;
    end
    if (stop) begin
      state_d   = ST_IDLE;
      smp_vld_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        state_d = ST_WARMUP;
        cnt_d   = '0;
        rel_d   = '0;
        good_d  = '0;
        miss_d  = '0;
      end
    end else if (state_q != ST_FAULT && smp_vld_q) begin
      cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      miss_d = fired_s_q ? 8'd0 : ((miss_q == '1) ? miss_q : miss_q + 8'd1);
      if (state_q == ST_TRAIN)
        good_d = (e3_q <= ERR_LOCK) ? ((good_q == '1) ? good_q : good_q + 8'd1) : 8'd0;
      if (miss_d >= MISS_LIMIT) begin
        state_d = ST_FAULT;
      end else begin
        case (state_q)
          ST_WARMUP: if (cnt_d >= {8'd0, WARMUP_CYCLES}) state_d = ST_TRAIN;
          ST_TRAIN:  if (good_d >= LOCK_CYCLES) state_d = ST_LOCKED;
          ST_LOCKED: if (e3_q > ERR_UNLOCK) begin
            state_d = ST_TRAIN;
            good_d  = '0;
            rel_d   = (rel_q == '1) ? rel_q : rel_q + 8'd1;
          end
          default: ;
        endcase
      end
    end
    freeze_d = !((state_d == ST_TRAIN) || (state_d == ST_LOCKED));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rel_q     <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      fired_s_q <= 1'b0;
      e2_q      <= '0;
      e3_q      <= '0;
      smp_vld_q <= 1'b0;
      freeze_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      fired_s_q <= fired_s_d;
      e2_q      <= e2_d;
      e3_q      <= e3_d;
      smp_vld_q <= smp_vld_d;
      freeze_q  <= freeze_d;
    end
  end

  assign input_current = is_run(state_q) ? stim_in : 8'd0;
  assign l3_freeze     = freeze_q;
  assign state         = state_q;
  assign cycle_count   = cnt_q;
  assign relearn_count = rel_q;
  assign err_l2_sample = e2_q;
endmodule
